// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 UART receiver with two-flop synchroniser, mid-bit sampling,
// a one-deep holding register and valid/full/frame-error/overrun flags.
module uart_receiver #(
    parameter int CLK_FREQ     = 12000000,
    parameter int BAUD         = 9600,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       rx,
    input  logic       rd_en,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_full,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_HIGH} state_t;

    state_t      r_state, w_next;
    logic        r_sync1, r_rx_s;
    logic [10:0] r_cnt;
    logic [2:0]  r_bit_idx;
    logic [7:0]  r_shift;
    logic        w_half, w_bit, w_sample, w_shift, w_done, w_ferr;

    assign w_half = r_cnt == 11'(HALF_BIT - 1);
    assign w_bit  = r_cnt == 11'(CLKS_PER_BIT - 1);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_sync1 <= 1'b1;
            r_rx_s  <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_rx_s  <= r_sync1;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:      w_next = r_rx_s ? S_IDLE : S_START;
            S_START:     w_next = !w_half ? S_START : (r_rx_s ? S_IDLE : S_DATA);
            S_DATA:      w_next = (w_bit && r_bit_idx == 3'd7) ? S_STOP : S_DATA;
            S_STOP:      w_next = !w_bit ? S_STOP : (r_rx_s ? S_IDLE : S_WAIT_HIGH);
            S_WAIT_HIGH: w_next = r_rx_s ? S_IDLE : S_WAIT_HIGH;
            default:     w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_shift  = (r_state == S_DATA) && w_bit;
        w_done   = (r_state == S_STOP) && w_bit && r_rx_s;
        w_ferr   = (r_state == S_STOP) && w_bit && !r_rx_s;
        w_sample = ((r_state == S_START) && w_half) || w_shift || ((r_state == S_STOP) && w_bit);
        busy     = r_state != S_IDLE;
    end

    // cnt restarts on every state change and every bit sample
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
        end else begin
            r_cnt     <= (r_state == S_IDLE || r_state == S_WAIT_HIGH || w_sample || w_next != r_state)
                         ? '0 : r_cnt + 11'd1;
            r_bit_idx <= (r_state == S_START) ? '0 : w_shift ? r_bit_idx + 3'd1 : r_bit_idx;
            r_shift   <= w_shift ? {r_rx_s, r_shift[7:1]} : r_shift;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            rx_full   <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            rx_data   <= w_done ? r_shift : rx_data;
            rx_valid  <= w_done;
            frame_err <= w_ferr;
            rx_full   <= w_done ? 1'b1 : rd_en ? 1'b0 : rx_full;
            // newest byte wins; overrun flags the unread one it replaced
            overrun   <= w_done ? (overrun | (rx_full & ~rd_en)) : rd_en ? 1'b0 : overrun;
        end
    end
endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: table-driven frames plus hand sequences for back-to-back,
// glitch, framing error and mid-frame reset, with a byte scoreboard.
module tb_uart_receiver;
    localparam int CPB = 16;
    localparam int HALF = CPB / 2;
    localparam int LAT = 3 + HALF + 9 * CPB;

    logic       clk, nrst, rx, rd_en;
    logic [7:0] rx_data;
    logic       rx_valid, rx_full, frame_err, overrun, busy;

    uart_receiver #(.CLK_FREQ(160), .BAUD(10)) dut (
        .clk(clk), .nrst(nrst), .rx(rx), .rd_en(rd_en),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_full(rx_full),
        .frame_err(frame_err), .overrun(overrun), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       rd;
        logic       exp_full;
        logic       exp_ovr;
    } vec_t;

    logic [7:0] sb[$];
    int n_chk = 0, n_fail = 0;
    int cyc = 0, n_valid = 0, n_ferr = 0, v_cyc = 0, t_start = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // monitor: counts pulses and pops the scoreboard on every rx_valid
    initial forever begin
        @(posedge clk);
        #1;
        cyc++;
        if (nrst) begin
            if (rx_valid) begin
                n_valid++;
                v_cyc = cyc;
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_valid: got %0h expected none", rx_data);
                end else chk("sb_data", {24'd0, rx_data}, {24'd0, sb.pop_front()});
            end
            if (frame_err) n_ferr++;
        end
    end

    task automatic send_frame(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        t_start = cyc;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic pulse_rd();
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        @(negedge clk);
    endtask

    vec_t vecs[4];
    int n0, f0, lat;

    initial begin
        vecs[0] = '{8'h53, 1'b1, 1'b1, 1'b0};
        vecs[1] = '{8'h70, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{8'h53, 1'b1, 1'b1, 1'b1};
        vecs[3] = '{8'hA5, 1'b1, 1'b1, 1'b0};
        nrst = 1'b0; rx = 1'b1; rd_en = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_data", {24'd0, rx_data}, 0);
        chk("rst_flags", {27'd0, rx_valid, rx_full, frame_err, overrun, busy}, 0);
        nrst = 1'b1;
        repeat (4) @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            n0 = n_valid; f0 = n_ferr;
            sb.push_back(vecs[i].data);
            send_frame(vecs[i].data, 1'b1);
            repeat (2 * CPB) @(negedge clk);
            chk("vec_valid_cnt", n_valid - n0, 1);
            chk("vec_ferr_cnt", n_ferr - f0, 0);
            chk("vec_data", {24'd0, rx_data}, {24'd0, vecs[i].data});
            chk("vec_full", {31'd0, rx_full}, {31'd0, vecs[i].exp_full});
            chk("vec_ovr", {31'd0, overrun}, {31'd0, vecs[i].exp_ovr});
            if (i == 0) begin
                lat = v_cyc - t_start;
                n_chk++;
                if (lat < LAT - 2 || lat > LAT + 2) begin
                    n_fail++;
                    $display("FAIL latency: got %0d cycles expected %0d +/-2", lat, LAT);
                end
            end
            if (vecs[i].rd) begin
                pulse_rd();
                chk("rd_full", {31'd0, rx_full}, 0);
                chk("rd_ovr", {31'd0, overrun}, 0);
            end
        end

        // back-to-back frames with a reader acknowledging each byte
        n0 = n_valid;
        sb.push_back(8'h00); sb.push_back(8'hFF); sb.push_back(8'hA5);
        fork
            begin
                send_frame(8'h00, 1'b1);
                send_frame(8'hFF, 1'b1);
                send_frame(8'hA5, 1'b1);
            end
            begin
                for (int k = 1; k <= 3; k++) begin
                    for (int t = 0; t < 600 && n_valid < n0 + k; t++) @(negedge clk);
                    if (n_valid < n0 + k) chk("b2b_timeout", n_valid - n0, k);
                    pulse_rd();
                end
            end
        join
        repeat (2 * CPB) @(negedge clk);
        chk("b2b_valid_cnt", n_valid - n0, 3);
        chk("b2b_ovr", {31'd0, overrun}, 0);
        chk("b2b_full", {31'd0, rx_full}, 0);

        // short glitch: start validation rejects it
        n0 = n_valid; f0 = n_ferr;
        rx = 1'b0;
        repeat (4) @(negedge clk);
        chk("glitch_busy_hi", {31'd0, busy}, 1);
        rx = 1'b1;
        repeat (10) @(negedge clk);
        chk("glitch_busy_lo", {31'd0, busy}, 0);
        chk("glitch_valid", n_valid - n0, 0);
        chk("glitch_ferr", n_ferr - f0, 0);

        // framing error followed by a held-low line
        n0 = n_valid; f0 = n_ferr;
        send_frame(8'h6E, 1'b0);
        repeat (3 * CPB) @(negedge clk);
        chk("ferr_busy", {31'd0, busy}, 1);
        chk("ferr_cnt", n_ferr - f0, 1);
        rx = 1'b1;
        repeat (6) @(negedge clk);
        chk("ferr_busy_lo", {31'd0, busy}, 0);
        chk("ferr_full", {31'd0, rx_full}, 0);
        chk("ferr_data", {24'd0, rx_data}, 32'hA5);
        chk("ferr_valid", n_valid - n0, 0);
        sb.push_back(8'h61);
        send_frame(8'h61, 1'b1);
        repeat (2 * CPB) @(negedge clk);
        chk("post_ferr_data", {24'd0, rx_data}, 32'h61);
        chk("post_ferr_full", {31'd0, rx_full}, 1);

        // reset in the middle of data bit 4
        n0 = n_valid;
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = i[0];
            repeat (CPB) @(negedge clk);
        end
        rx = 1'b1;
        repeat (HALF) @(negedge clk);
        chk("pre_rst_busy", {31'd0, busy}, 1);
        nrst = 1'b0;
        #1;
        chk("mid_rst_data", {24'd0, rx_data}, 0);
        chk("mid_rst_flags", {27'd0, rx_valid, rx_full, frame_err, overrun, busy}, 0);
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        repeat (12 * CPB) @(negedge clk);
        chk("mid_rst_no_valid", n_valid - n0, 0);
        chk("mid_rst_idle", {31'd0, busy}, 0);
        sb.push_back(8'h3C);
        send_frame(8'h3C, 1'b1);
        repeat (2 * CPB) @(negedge clk);
        chk("post_rst_data", {24'd0, rx_data}, 32'h3C);
        chk("post_rst_valid", n_valid - n0, 1);
        chk("sb_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- 8N1 UART receiver. It is the receive-side counterpart of the team's 12 MHz / 9600-baud transmitter.
- It synchronises the serial `rx` line, validates the start bit, and samples 8 data bits LSB-first at mid-bit. It checks the stop bit and presents each byte in a one-deep holding register with valid/full/error flags.
- It sits between the board RX pin and the byte consumer. The loopback bench connects the transmitter's `tx` output to this block's `rx` input.

Parameters:
- CLK_FREQ, 12000000, system clock frequency in Hz.
- BAUD, 9600, serial bit rate.
- CLKS_PER_BIT, CLK_FREQ/BAUD (1250), clocks per bit period; integer division.
- HALF_BIT, CLKS_PER_BIT/2 (625), clocks from start-bit entry to the start-bit mid-sample.

Ports:
- clk  input  1  system clock, rising edge.
- nrst  input  1  asynchronous active-low reset.
- rx  input  1  serial line; idles high; asynchronous to clk.
- rd_en  input  1  consumer read strobe; clears rx_full.
- rx_data  output  8  last received byte.
- rx_valid  output  1  one-cycle pulse when rx_data is updated.
- rx_full  output  1  holding register contains an unread byte.
- frame_err  output  1  one-cycle pulse when the stop bit is sampled low.
- overrun  output  1  sticky; a byte arrived while rx_full=1.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset: nrst=0 asynchronously forces:
  - state=IDLE, synchroniser flops=1, all counters=0.
  - rx_data=8'h00; rx_valid, rx_full, frame_err, overrun, busy all 0.
  - Reset mid-frame abandons the frame with no outputs.
- Synchroniser: two flops, reset value 1. The FSM uses only the second flop's output, rx_s.
- Counters:
  - cnt: 11 bits, counts 0..CLKS_PER_BIT-1; cleared on every state entry and every bit sample.
  - bit_idx: 3 bits.
- FSM:
  - IDLE: rx_s==0 -> START, cnt=0.
  - START: cnt increments each cycle. At cnt==HALF_BIT-1, sample rx_s:
    - rx_s==0 -> DATA, cnt=0, bit_idx=0.
    - rx_s==1 -> IDLE. This is a glitch/false start; no outputs.
  - DATA: at cnt==CLKS_PER_BIT-1, shift rx_s into shift[7] (right shift, so LSB arrives first).
    - bit_idx==7 -> STOP, cnt=0.
    - Otherwise bit_idx+1.
  - STOP: at cnt==CLKS_PER_BIT-1, sample rx_s:
    - rx_s==1: next cycle rx_data<=shift, rx_valid=1 for one cycle, rx_full<=1; state -> IDLE. The half stop bit remaining allows resynchronisation to back-to-back frames.
    - rx_s==0: next cycle frame_err=1 for one cycle; rx_data and rx_full unchanged; state -> WAIT_HIGH.
  - WAIT_HIGH: stays until rx_s==1, then -> IDLE. A held-low break line therefore yields exactly one frame_err.
- Latency: rx_valid rises 11,878 clocks (±2) after the rx falling edge. This is 625 + 9×1250 plus synchroniser and registration delay.
- rx_full / overrun:
  - rd_en with no byte completing: rx_full<=0, overrun<=0.
  - Byte completing while rx_full=1 and no rd_en in that cycle: overrun<=1 and rx_data is overwritten (newest byte wins).
  - Byte completing in the same cycle as rd_en: new byte loaded, rx_full stays 1, overrun stays 0.
  - rd_en while rx_full=0: no effect.
- rd_en and the framing logic are independent; rd_en never disturbs an in-progress frame.

Test Plan:
- Loopback/direct drive of 8'h53 at 9600 baud after nrst released at 2.15 ms -> rx_valid pulses once, rx_data=8'h53, rx_full=1, frame_err=0, rx_valid within 11,876–11,880 clocks of the start edge.
- Back-to-back 8'h00, 8'hFF, 8'hA5 with no idle gap and rd_en after each rx_valid -> three rx_valid pulses with the correct bytes, overrun=0.
- rx low for 300 clocks then high -> busy rises then falls at the start mid-sample, no rx_valid, no frame_err, state IDLE.
- 8'h6E with the stop bit driven 0, held low 3 bit times, then high -> exactly one frame_err pulse, rx_full unchanged, busy until rx returns high; next frame 8'h61 received correctly.
- Two frames (8'h70, 8'h53) with no rd_en -> overrun=1, rx_data=8'h53. Then rd_en -> rx_full=0, overrun=0.
- nrst pulsed low during DATA bit 4 of a frame -> all outputs reset immediately, no rx_valid for that frame; the following frame 8'h3C is received correctly.
